// File: rtl/rv32_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32_exec_ctrl
// Purpose  : Single-cycle RV32I execute/control slice. Holds the program
//            counter, decodes the current instruction into datapath control
//            signals, performs the ALU operation, computes PC+4 and the
//            branch/jump target, and selects the next PC.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   1   rising-edge clock for the PC register
//   rst         in   1   synchronous active-high reset (pc <= 0)
//   instr       in  32   current instruction (addressed by pc)
//   rd1         in  32   register read data 1 (ALU operand A)
//   rd2         in  32   register read data 2
//   imm_ext     in  32   sign-extended immediate
//   pc          out 32   current program counter
//   pc_plus4    out 32   pc + 4
//   pc_target   out 32   pc + imm_ext
//   alu_result  out 32   ALU output
//   zero        out  1   alu_result == 0
//   pc_src      out  1   next-PC select (1 = pc_target)
//   reg_write   out  1   register-file write enable
//   imm_src     out  2   immediate format: 00 I, 01 S, 10 B, 11 J
//   alu_src     out  1   ALU operand B select (1 = imm_ext)
//   alu_control out  3   ALU operation code
//   mem_write   out  1   data-memory write enable
//   result_src  out  2   writeback select: 00 ALU, 01 mem, 10 PC+4
// ============================================================================
module rv32_exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm_ext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_target,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        pc_src,
  output logic        reg_write,
  output logic [1:0]  imm_src,
  output logic        alu_src,
  output logic [2:0]  alu_control,
  output logic        mem_write,
  output logic [1:0]  result_src
);

  // Opcodes recognised by the main decoder
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Decoder class handed from the main decoder to the ALU decoder
  localparam logic [1:0] AOP_ADD  = 2'b00;
  localparam logic [1:0] AOP_SUB  = 2'b01;
  localparam logic [1:0] AOP_FUNC = 2'b10;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        op5;
  logic        f7_5;
  logic        branch;
  logic        jump;
  logic [1:0]  alu_op;
  logic [31:0] src_b;
  logic [31:0] pc_next;

  // Instruction bits this slice never looks at (register indices, upper
  // immediate bits); gathered here so they are visibly intentional.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];
  assign op5    = instr[5];
  assign f7_5   = instr[30];

  // --------------------------------------------------------------------------
  // Main decoder. Unknown opcodes fall through with everything 0, which
  // gives no register write, no store and a sequential PC.
  // --------------------------------------------------------------------------
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = AOP_ADD;
    jump       = 1'b0;
    unique case (op)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      OP_SW: begin
        imm_src   = 2'b01;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = AOP_FUNC;
      end
      OP_BEQ: begin
        imm_src = 2'b10;
        branch  = 1'b1;
        alu_op  = AOP_SUB;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = AOP_FUNC;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = 2'b11;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU decoder. Subtract for funct3 000 requires op5 so that addi (op5 = 0)
  // is never mistaken for sub even when its immediate has bit 30 set.
  // --------------------------------------------------------------------------
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      AOP_SUB:  alu_control = ALU_SUB;
      AOP_FUNC: begin
        case (funct3)
          3'b000:  alu_control = (op5 & f7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:  alu_control = ALU_ADD;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  assign src_b = alu_src ? imm_ext : rd2;

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      ALU_ADD: alu_result = rd1 + src_b;
      ALU_SUB: alu_result = rd1 - src_b;
      ALU_AND: alu_result = rd1 & src_b;
      ALU_OR:  alu_result = rd1 | src_b;
      ALU_SLT: alu_result = {31'd0, ($signed(rd1) < $signed(src_b))};
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // --------------------------------------------------------------------------
  // PC adders and next-PC selection (both adders wrap modulo 2^32)
  // --------------------------------------------------------------------------
  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_ext;
  assign pc_src    = (branch & zero) | jump;
  assign pc_next   = pc_src ? pc_target : pc_plus4;

  // Reset wins over any pending branch/jump; no asynchronous path.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'd0;
    end else begin
      pc <= pc_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_exec_ctrl
// Purpose  : Self-checking bench for rv32_exec_ctrl. A behavioural model of
//            the instruction semantics predicts every output each cycle;
//            directed scenarios pin the model with hand-computed literals,
//            followed by randomized instruction/operand streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_exec_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_ext;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        zero;
  logic        pc_src;
  logic        reg_write;
  logic [1:0]  imm_src;
  logic        alu_src;
  logic [2:0]  alu_control;
  logic        mem_write;
  logic [1:0]  result_src;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  rv32_exec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .rd1         (rd1),
    .rd2         (rd2),
    .imm_ext     (imm_ext),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_target   (pc_target),
    .alu_result  (alu_result),
    .zero        (zero),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .imm_src     (imm_src),
    .alu_src     (alu_src),
    .alu_control (alu_control),
    .mem_write   (mem_write),
    .result_src  (result_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: what each instruction means, expressed directly.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic [31:0] alu_result;
    logic        zero;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  imm_src;
    logic        alu_src;
    logic [2:0]  alu_control;
    logic        mem_write;
    logic [1:0]  result_src;
  } exp_t;

  function automatic exp_t model(input logic [31:0] p, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
    exp_t        e;
    logic [31:0] opb;
    string       kind;
    e = '0;
    e.pc_plus4  = p + 32'd4;
    e.pc_target = p + imm;
    case (ins[6:0])
      7'b0000011: kind = "lw";
      7'b0100011: kind = "sw";
      7'b0110011: kind = "r";
      7'b1100011: kind = "beq";
      7'b0010011: kind = "i";
      7'b1101111: kind = "jal";
      default:    kind = "other";
    endcase
    e.reg_write  = (kind == "lw" || kind == "r" || kind == "i" || kind == "jal");
    e.mem_write  = (kind == "sw");
    e.alu_src    = (kind == "lw" || kind == "sw" || kind == "i");
    e.imm_src    = (kind == "sw") ? 2'd1 : (kind == "beq") ? 2'd2 : (kind == "jal") ? 2'd3 : 2'd0;
    e.result_src = (kind == "lw") ? 2'd1 : (kind == "jal") ? 2'd2 : 2'd0;
    opb = e.alu_src ? imm : b;
    // default: addition (loads, stores, jal, unknown opcodes, unlisted funct3)
    e.alu_control = 3'b000;
    e.alu_result  = a + opb;
    if (kind == "beq") begin
      e.alu_control = 3'b001;
      e.alu_result  = a - opb;
    end else if (kind == "r" || kind == "i") begin
      case (ins[14:12])
        3'b000: if (kind == "r" && ins[30]) begin
          e.alu_control = 3'b001;
          e.alu_result  = a - opb;
        end
        3'b010: begin
          e.alu_control = 3'b101;
          e.alu_result  = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
        end
        3'b110: begin
          e.alu_control = 3'b011;
          e.alu_result  = a | opb;
        end
        3'b111: begin
          e.alu_control = 3'b010;
          e.alu_result  = a & opb;
        end
        default: ;
      endcase
    end
    e.zero   = (e.alu_result == 32'd0);
    // beq is taken exactly when the two registers are equal
    e.pc_src = (kind == "jal") || (kind == "beq" && a == b);
    return e;
  endfunction

  logic [31:0] m_pc;
  exp_t        cur;

  always_comb cur = model(m_pc, instr, rd1, rd2, imm_ext);

  always @(posedge clk) begin
    if (rst) m_pc <= 32'd0;
    else     m_pc <= cur.pc_src ? cur.pc_target : cur.pc_plus4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model, every cycle, away
  // from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc",          pc,                  m_pc);
      chk("pc_plus4",    pc_plus4,            cur.pc_plus4);
      chk("pc_target",   pc_target,           cur.pc_target);
      chk("alu_result",  alu_result,          cur.alu_result);
      chk("zero",        {31'd0, zero},       {31'd0, cur.zero});
      chk("pc_src",      {31'd0, pc_src},     {31'd0, cur.pc_src});
      chk("reg_write",   {31'd0, reg_write},  {31'd0, cur.reg_write});
      chk("imm_src",     {30'd0, imm_src},    {30'd0, cur.imm_src});
      chk("alu_src",     {31'd0, alu_src},    {31'd0, cur.alu_src});
      chk("alu_control", {29'd0, alu_control},{29'd0, cur.alu_control});
      chk("mem_write",   {31'd0, mem_write},  {31'd0, cur.mem_write});
      chk("result_src",  {30'd0, result_src}, {30'd0, cur.result_src});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im);
    instr = i; rd1 = a; rd2 = b; imm_ext = im;
  endtask

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] LW   = 32'h0000_0003;
  localparam logic [31:0] SW   = 32'h0000_0023;

  // Reset, then jal from 0 to reach an arbitrary PC.
  task automatic goto_pc(input logic [31:0] target);
    rst = 1'b1;
    set_in(NOP, 0, 0, 0);
    tick();
    rst = 1'b0;
    set_in(JAL, 0, 0, target);
    tick();
    chk("goto_pc", pc, target);
  endtask

  initial begin
    logic [6:0] ops [7];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b1100011; ops[4] = 7'b0010011; ops[5] = 7'b1101111;
    ops[6] = 7'b0000000;

    rst = 1'b1;
    set_in(NOP, 0, 0, 32'h0000_1234);
    tick();
    tick();
    cmp_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    chk("rst_pc_target", pc_target, 32'h0000_1234);
    rst = 1'b0;
    tick(); chk("step4", pc, 32'd4);
    tick(); chk("step8", pc, 32'd8);
    tick(); chk("step12", pc, 32'd12);

    // R-type sub x10,x10,x11
    set_in(32'h40B5_0533, 32'd10, 32'd3, 32'd0);
    @(negedge clk);
    chk("sub_ctl", {29'd0, alu_control}, 32'd1);
    chk("sub_res", alu_result, 32'd7);
    chk("sub_rw", {31'd0, reg_write}, 32'd1);
    chk("sub_asrc", {31'd0, alu_src}, 32'd0);
    chk("sub_rsrc", {30'd0, result_src}, 32'd0);

    // slt signed
    set_in(32'h00B5_2533, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk);
    chk("slt_res", alu_result, 32'd1);
    chk("slt_zero", {31'd0, zero}, 32'd0);
    set_in(32'h00B5_2533, 32'd1, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    chk("slt_swap_res", alu_result, 32'd0);
    chk("slt_swap_zero", {31'd0, zero}, 32'd1);
    tick();

    // beq taken / not taken at 0x20
    goto_pc(32'h20);
    set_in(BEQ, 32'd5, 32'd5, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("beq_taken_src", {31'd0, pc_src}, 32'd1);
    tick();
    chk("beq_taken_pc", pc, 32'h18);
    set_in(NOP, 0, 0, 0);
    tick(); tick();
    chk("back_to_20", pc, 32'h20);
    set_in(BEQ, 32'd5, 32'd6, 32'hFFFF_FFF8);
    tick();
    chk("beq_not_taken_pc", pc, 32'h24);

    // lw / sw
    set_in(LW, 32'h100, 32'd0, 32'd8);
    @(negedge clk);
    chk("lw_res", alu_result, 32'h108);
    chk("lw_rsrc", {30'd0, result_src}, 32'd1);
    chk("lw_mw", {31'd0, mem_write}, 32'd0);
    set_in(SW, 32'h100, 32'd0, 32'd8);
    @(negedge clk);
    chk("sw_mw", {31'd0, mem_write}, 32'd1);
    chk("sw_rw", {31'd0, reg_write}, 32'd0);
    chk("sw_isrc", {30'd0, imm_src}, 32'd1);
    tick();

    // jal at 0x40, then reset overriding a jal
    goto_pc(32'h40);
    set_in(JAL, 0, 0, 32'h10);
    @(negedge clk);
    chk("jal_src", {31'd0, pc_src}, 32'd1);
    chk("jal_rsrc", {30'd0, result_src}, 32'd2);
    chk("jal_plus4", pc_plus4, 32'h44);
    tick();
    chk("jal_pc", pc, 32'h50);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pending_pc", pc, 32'h50);
    tick();
    chk("rst_over_jal", pc, 32'd0);
    rst = 1'b0;

    // PC wrap-around
    goto_pc(32'hFFFF_FFFC);
    set_in(NOP, 0, 0, 0);
    tick();
    chk("wrap_pc", pc, 32'd0);

    // beq self-loop
    goto_pc(32'h30);
    set_in(BEQ, 32'd9, 32'd9, 32'd0);
    tick(); chk("self_loop1", pc, 32'h30);
    tick(); chk("self_loop2", pc, 32'h30);

    // Randomized stream, checked cycle by cycle by the compare process
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ri;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rim;
      ri = $urandom;
      if ($urandom_range(0, 9) != 0) ri[6:0] = ops[$urandom_range(0, 6)];
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom_range(0, 8);
        2: ra = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: ra = 32'h8000_0000 + $urandom_range(0, 3);
      endcase
      rb  = ($urandom_range(0, 2) == 0) ? ra : (($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 8));
      rim = ($urandom_range(0, 1) == 0) ? $urandom : (32'($signed($urandom_range(0, 64)) - 32) << 2);
      if ($urandom_range(0, 7) == 0) rim = 32'h0 - ra;
      rst = ($urandom_range(0, 29) == 0);
      set_in(ri, ra, rb, rim);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
